axi4r_arbiter: RTL and testbench
================================

// Module: axi4r_arbiter
// PURPOSE
// Shares one AXI4 read channel (AR+R) between NUM_M requesting masters, e.g. several DMA/lookup
// engines behind a single memory read port. Round-robin AR grant; one outstanding burst at a time;
// R beats routed back to the granted master until RLAST. Also checks burst length against ARLEN.
// PARAMETERS
// NUM_M   2   number of upstream masters (>=2)
// IDX_W   $clog2(NUM_M)   grant index width (derived, not overridden)
// PORTS
// clk          in   1          clock
// rst          in   1          asynchronous active-high reset
// m_arvalid    in   NUM_M      per-master AR valid
// m_arready    out  NUM_M      per-master AR ready
// m_araddr     in   NUM_M*32   per-master address, master i at [32*i +: 32]
// m_arid       in   NUM_M*4    per-master ID
// m_arlen      in   NUM_M*8    per-master burst length-1
// m_arsize     in   NUM_M*3    per-master beat size
// m_arburst    in   NUM_M*2    per-master burst type
// m_rvalid     out  NUM_M      per-master R valid
// m_rready     in   NUM_M      per-master R ready
// m_rdata      out  NUM_M*64   per-master read data
// m_rresp      out  NUM_M*2    per-master response
// m_rlast      out  NUM_M      per-master last beat
// m_rid        out  NUM_M*4    per-master returned ID
// s_ar*/s_r*   AXI4 read master toward the slave, widths 32/4/8/3/2 (AR), 64/2/1/4 (R)
// busy         out  1          burst in progress (state != IDLE)
// grant        out  IDX_W      index of current/last granted master
// len_err      out  1          one-cycle pulse: beat count disagreed with ARLEN+1
// BEHAVIOUR
// Reset (async, rst=1): state IDLE, rr pointer = NUM_M-1 (master 0 highest priority first),
//   grant=0, beat count 0; all *valid/*ready outputs 0, s_ar* fields 0, len_err 0, busy 0.
// States: IDLE -> ADDR -> DATA -> IDLE.
// IDLE: pick first i with m_arvalid[i], searching from ptr+1 cyclically. m_arready[i]=1 in that
//   cycle (combinational on m_arvalid); AR fields captured into registers, grant<=i, -> ADDR.
//   No request: stay IDLE, all m_arready 0.
// ADDR: s_arvalid=1 with registered fields (stable while stalled); on s_arready -> DATA, count<=0.
//   All m_arready 0 in ADDR and DATA.
// DATA: m_r*[grant] = s_r* combinationally; s_rready = m_rready[grant]; other masters see
//   rvalid=0, data/resp/last/id=0. Each s_rvalid&s_rready beat: count++ (8-bit, saturating at 255).
//   Beat with rlast: -> IDLE, ptr<=grant. len_err pulses next cycle if count != arlen at that beat.
//   Beat with count==arlen and no rlast: len_err pulses once; keep forwarding until rlast.
// Latency: AR accept at T -> s_arvalid at T+1. Last beat at T -> state IDLE at T+1, next master
//   accepted at T+1 earliest (one-cycle bubble between bursts).
// Fairness: a master just served is lowest priority next round; requester waits <= NUM_M-1 bursts.
// Simultaneous: arvalid from all masters in IDLE -> only one arready asserted.
// Mid-operation reset: burst abandoned, outputs to reset values immediately; no replay.
// m_arvalid drop while not granted: legal-ignored (no capture). R beats arriving in IDLE/ADDR
//   (slave protocol error): s_rready=0, beats not consumed.
// STRUCTURE
// Shared package axi4r_pkg: AXI4R_ADDR_W=32, AXI4R_ID_W=4, AXI4R_LEN_W=8, AXI4R_DATA_W=64,
//   burst encodings (FIXED/INCR/WRAP), arb_state_e {IDLE,ADDR,DATA}.
// Sub-module rr_pick #(N): combinational round-robin picker (req, ptr -> gnt_valid, gnt_idx).
// TESTING
// 1 Reset, m0 arvalid addr=0x1000 len=3 -> m_arready[0] 1 cycle, s_araddr=0x1000 next cycle,
//   4 beats to m0, rlast on beat 4, len_err=0, busy falls after last beat.
// 2 m0,m1 request together repeatedly -> grants alternate 0,1,0,1; never two arready same cycle.
// 3 s_arready held 0 for 5 cycles -> s_ar* stable, s_arvalid held, no R routing.
// 4 m1 rready toggling -> s_rready mirrors m_rready[1]; beats never lost or duplicated.
// 5 arlen=3, slave gives rlast on beat 2 -> len_err pulse 1 cycle, return IDLE; arlen=1,
//   rlast on beat 4 -> single len_err pulse, all 4 beats forwarded.
// 6 rst asserted mid-DATA -> outputs zero asynchronously, grant=0; m0 served first afterwards.

Source files
------------

// File: rtl/axi4r_pkg.sv
// Shared AXI4 read-channel widths, encodings and arbiter state type.
package axi4r_pkg;

    localparam int unsigned AXI4R_ADDR_W  = 32;
    localparam int unsigned AXI4R_ID_W    = 4;
    localparam int unsigned AXI4R_LEN_W   = 8;
    localparam int unsigned AXI4R_DATA_W  = 64;
    localparam int unsigned AXI4R_SIZE_W  = 3;
    localparam int unsigned AXI4R_BURST_W = 2;
    localparam int unsigned AXI4R_RESP_W  = 2;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi4r_burst_e;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } arb_state_e;

    typedef struct packed {
        logic [AXI4R_ADDR_W-1:0]  addr;
        logic [AXI4R_ID_W-1:0]    id;
        logic [AXI4R_LEN_W-1:0]   len;
        logic [AXI4R_SIZE_W-1:0]  size;
        logic [AXI4R_BURST_W-1:0] burst;
    } axi4r_ar_t;

    function automatic logic [AXI4R_LEN_W-1:0] sat_inc(input logic [AXI4R_LEN_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after ptr, searching cyclically.
module rr_pick #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IDX_W'((32'(ptr) + k) % N);
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/axi4r_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel among NUM_M masters, one burst at a time,
// with a beat-count versus ARLEN check.
module axi4r_arbiter
    import axi4r_pkg::*;
#(
    parameter int unsigned NUM_M = 2,
    parameter int unsigned IDX_W = $clog2(NUM_M)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_M-1:0]      m_arvalid,
    output logic [NUM_M-1:0]      m_arready,
    input  logic [NUM_M*32-1:0]   m_araddr,
    input  logic [NUM_M*4-1:0]    m_arid,
    input  logic [NUM_M*8-1:0]    m_arlen,
    input  logic [NUM_M*3-1:0]    m_arsize,
    input  logic [NUM_M*2-1:0]    m_arburst,
    output logic [NUM_M-1:0]      m_rvalid,
    input  logic [NUM_M-1:0]      m_rready,
    output logic [NUM_M*64-1:0]   m_rdata,
    output logic [NUM_M*2-1:0]    m_rresp,
    output logic [NUM_M-1:0]      m_rlast,
    output logic [NUM_M*4-1:0]    m_rid,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    output logic [31:0]           s_araddr,
    output logic [3:0]            s_arid,
    output logic [7:0]            s_arlen,
    output logic [2:0]            s_arsize,
    output logic [1:0]            s_arburst,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    input  logic [63:0]           s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rlast,
    input  logic [3:0]            s_rid,
    output logic                  busy,
    output logic [IDX_W-1:0]      grant,
    output logic                  len_err
);

    arb_state_e             state_q;
    logic [IDX_W-1:0]       ptr_q;
    logic [IDX_W-1:0]       grant_q;
    logic [AXI4R_LEN_W-1:0] count_q;
    logic                   len_err_q;
    logic                   err_seen_q;
    axi4r_ar_t              ar_q;

    axi4r_ar_t              req_ar [NUM_M];
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic                   rd_active;
    logic                   beat;

    for (genvar i = 0; i < NUM_M; i++) begin : g_unpack
        assign req_ar[i] = {m_araddr[32*i +: 32], m_arid[4*i +: 4], m_arlen[8*i +: 8],
                            m_arsize[3*i +: 3], m_arburst[2*i +: 2]};
    end

    rr_pick #(
        .N     (NUM_M),
        .IDX_W (IDX_W)
    ) u_pick (
        .req       (m_arvalid),
        .ptr       (ptr_q),
        .gnt_valid (pick_valid),
        .gnt_idx   (pick_idx)
    );

    // Ready is gated by rst so no handshake is advertised while reset is held.
    always_comb begin
        m_arready = '0;
        if (state_q == IDLE && pick_valid && !rst) begin
            m_arready[pick_idx] = 1'b1;
        end
    end

    assign rd_active = (state_q == DATA);
    assign beat      = rd_active & s_rvalid & s_rready;

    always_comb begin
        m_rvalid = '0;
        m_rdata  = '0;
        m_rresp  = '0;
        m_rlast  = '0;
        m_rid    = '0;
        s_rready = rd_active & m_rready[grant_q];
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (rd_active && grant_q == IDX_W'(i)) begin
                m_rvalid[i]        = s_rvalid;
                m_rdata[64*i +: 64] = s_rdata;
                m_rresp[2*i +: 2]  = s_rresp;
                m_rlast[i]         = s_rlast;
                m_rid[4*i +: 4]    = s_rid;
            end
        end
    end

    assign s_arvalid = (state_q == ADDR);
    assign s_araddr  = ar_q.addr;
    assign s_arid    = ar_q.id;
    assign s_arlen   = ar_q.len;
    assign s_arsize  = ar_q.size;
    assign s_arburst = ar_q.burst;
    assign busy      = (state_q != IDLE);
    assign grant     = grant_q;
    assign len_err   = len_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= IDX_W'(NUM_M - 1);
            grant_q    <= '0;
            count_q    <= '0;
            len_err_q  <= 1'b0;
            err_seen_q <= 1'b0;
            ar_q       <= '0;
        end else begin
            len_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        ar_q    <= req_ar[pick_idx];
                        grant_q <= pick_idx;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (s_arready) begin
                        state_q    <= DATA;
                        count_q    <= '0;
                        err_seen_q <= 1'b0;
                    end
                end
                DATA: begin
                    if (beat) begin
                        count_q <= sat_inc(count_q);
                        // count_q holds beats already taken, so the expected last beat sees len.
                        if (s_rlast) begin
                            state_q <= IDLE;
                            ptr_q   <= grant_q;
                            if (!err_seen_q && count_q != ar_q.len) begin
                                len_err_q <= 1'b1;
                            end
                        end else if (!err_seen_q && count_q == ar_q.len) begin
                            len_err_q  <= 1'b1;
                            err_seen_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4r_arbiter.sv
// Self-checking bench for axi4r_arbiter: directed table, hand sequences and randomized bursts.
module tb_axi4r_arbiter;
    import axi4r_pkg::*;

    localparam int N  = 3;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [N*32-1:0] m_araddr;
    logic [N*4-1:0]  m_arid, m_rid;
    logic [N*8-1:0]  m_arlen;
    logic [N*3-1:0]  m_arsize;
    logic [N*2-1:0]  m_arburst, m_rresp;
    logic [N*64-1:0] m_rdata;
    logic            s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [31:0]     s_araddr;
    logic [3:0]      s_arid, s_rid;
    logic [7:0]      s_arlen;
    logic [2:0]      s_arsize;
    logic [1:0]      s_arburst, s_rresp;
    logic [63:0]     s_rdata;
    logic            busy, len_err;
    logic [IW-1:0]   grant;

    logic [31:0] req_addr  [N];
    logic [3:0]  req_id    [N];
    logic [7:0]  req_len   [N];
    logic [2:0]  req_size  [N];
    logic [1:0]  req_burst [N];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    always_comb begin
        m_araddr  = '0;
        m_arid    = '0;
        m_arlen   = '0;
        m_arsize  = '0;
        m_arburst = '0;
        for (int i = 0; i < N; i++) begin
            m_araddr[32*i +: 32] = req_addr[i];
            m_arid[4*i +: 4]     = req_id[i];
            m_arlen[8*i +: 8]    = req_len[i];
            m_arsize[3*i +: 3]   = req_size[i];
            m_arburst[2*i +: 2]  = req_burst[i];
        end
    end

    axi4r_arbiter #(.NUM_M(N)) dut (
        .clk(clk), .rst(rst),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rid(m_rid),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rid(s_rid),
        .busy(busy), .grant(grant), .len_err(len_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic set_req(input int m, input logic [31:0] a, input logic [3:0] id,
                           input logic [7:0] len);
        req_addr[m]  = a;
        req_id[m]    = id;
        req_len[m]   = len;
        req_size[m]  = 3'd3;
        req_burst[m] = BURST_INCR;
    endtask

    // Rotating priority: rank 0 is the master right after the last one served.
    function automatic int model_pick(input logic [N-1:0] mask, input int last);
        int best, best_rank, rank;
        best = -1;
        best_rank = N;
        for (int i = 0; i < N; i++) begin
            rank = (i - last - 1 + 2 * N) % N;
            if (mask[i] && rank < best_rank) begin
                best = i;
                best_rank = rank;
            end
        end
        return best;
    endfunction

    task automatic req_phase(input logic [N-1:0] mask, output int g, output int waits);
        g = 0;
        waits = 0;
        m_arvalid = mask;
        #1;
        while (m_arready == '0 && waits < 8) begin
            step();
            #1;
            waits++;
        end
        chk("arready_seen", 64'(m_arready != '0), 1);
        chk("arready_single", 64'($countones(m_arready) <= 1), 1);
        chk("arready_in_mask", 64'(m_arready & ~mask), 0);
        for (int i = 0; i < N; i++) if (m_arready[i]) g = i;
        step();
        #1;
        chk("arready_drop", 64'(m_arready), 0);
        chk("grant_reg", 64'(grant), 64'(g));
        chk("s_arvalid", 64'(s_arvalid), 1);
        chk("busy_rise", 64'(busy), 1);
        chk("s_araddr", 64'(s_araddr), 64'(req_addr[g]));
        chk("s_arid", 64'(s_arid), 64'(req_id[g]));
        chk("s_arlen", 64'(s_arlen), 64'(req_len[g]));
        chk("s_arsize_burst", 64'({s_arsize, s_arburst}), 64'({req_size[g], req_burst[g]}));
        m_arvalid = '0;
    endtask

    task automatic serve(input int g, input int nbeats, input int stall, input bit rnd,
                         output int got, output int errs);
        int b, cyc;
        logic [N-1:0] exp_rv;
        logic [63:0]  other;
        got = 0;
        errs = 0;
        for (int s = 0; s < stall; s++) begin
            s_arready = 1'b0;
            s_rvalid = 1'b1;
            s_rlast = 1'b0;
            m_rready = '1;
            #1;
            errs += int'(len_err);
            chk("stall_arvalid", 64'(s_arvalid), 1);
            chk("stall_araddr", 64'(s_araddr), 64'(req_addr[g]));
            chk("stall_arlen", 64'(s_arlen), 64'(req_len[g]));
            chk("stall_no_srready", 64'(s_rready), 0);
            chk("stall_no_mrvalid", 64'(m_rvalid), 0);
            step();
        end
        s_rvalid = 1'b0;
        s_arready = 1'b1;
        #1;
        errs += int'(len_err);
        chk("ar_handshake", 64'(s_arvalid), 1);
        step();
        s_arready = 1'b0;
        b = 0;
        cyc = 0;
        while (b < nbeats && cyc < 300) begin
            s_rvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_rdata = {$urandom(), $urandom()};
            s_rresp = 2'($urandom());
            s_rid = req_id[g];
            s_rlast = (b == nbeats - 1);
            m_rready = rnd ? N'($urandom()) : '1;
            #1;
            errs += int'(len_err);
            exp_rv = '0;
            if (s_rvalid) exp_rv[g] = 1'b1;
            chk("rready_mirror", 64'(s_rready), 64'(m_rready[g]));
            chk("rvalid_route", 64'(m_rvalid), 64'(exp_rv));
            if (m_rvalid[g]) begin
                chk("rdata", m_rdata[64*g +: 64], s_rdata);
                chk("rlast_rid_rresp", 64'({m_rlast[g], m_rid[4*g +: 4], m_rresp[2*g +: 2]}),
                    64'({s_rlast, s_rid, s_rresp}));
            end
            other = '0;
            for (int i = 0; i < N; i++) begin
                if (i != g) other |= m_rdata[64*i +: 64] |
                                     64'({m_rresp[2*i +: 2], m_rid[4*i +: 4], m_rlast[i]});
            end
            chk("others_quiet", other, 0);
            if (s_rvalid && s_rready) begin
                b++;
                if (m_rvalid[g] && m_rready[g]) got++;
            end
            step();
            cyc++;
        end
        if (b < nbeats) chk("beat_timeout", 64'(b), 64'(nbeats));
        s_rvalid = 1'b0;
        s_rlast = 1'b0;
        m_rready = '0;
        #1;
        errs += int'(len_err);
        chk("busy_fall", 64'(busy), 0);
        step();
        #1;
        errs += int'(len_err);
    endtask

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        int          nbeats;
        int          stall;
        bit          rnd;
        int          exp_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int g, w, got, errs, last, exp_g, nb, exp_err;
        logic [N-1:0] mask;

        vecs[0] = '{0, 32'h1000, 4'h1, 8'd3, 4, 0, 1'b0, 0};
        vecs[1] = '{1, 32'h2000, 4'h2, 8'd3, 4, 5, 1'b0, 0};
        vecs[2] = '{1, 32'h3000, 4'h3, 8'd7, 8, 0, 1'b1, 0};
        vecs[3] = '{0, 32'h4000, 4'h4, 8'd3, 2, 0, 1'b0, 1};
        vecs[4] = '{2, 32'h5000, 4'h5, 8'd1, 4, 1, 1'b0, 1};
        vecs[5] = '{2, 32'h6000, 4'h6, 8'd0, 1, 2, 1'b1, 0};
        vecs[6] = '{0, 32'h7000, 4'h7, 8'd0, 3, 0, 1'b1, 1};

        for (int i = 0; i < N; i++) set_req(i, 32'h0, 4'h0, 8'h0);
        m_rready = '0;
        s_arready = 1'b0;
        s_rvalid = 1'b0;
        s_rdata = '0;
        s_rresp = '0;
        s_rlast = 1'b0;
        s_rid = '0;
        m_arvalid = '1;
        #2;
        chk("rst_arready", 64'(m_arready), 0);
        chk("rst_arvalid", 64'(s_arvalid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_grant", 64'(grant), 0);
        chk("rst_len_err", 64'(len_err), 0);
        chk("rst_araddr", 64'(s_araddr), 0);
        chk("rst_rready", 64'(s_rready), 0);
        m_arvalid = '0;
        step();
        rst = 1'b0;
        step();

        foreach (vecs[k]) begin
            set_req(vecs[k].m, vecs[k].addr, vecs[k].id, vecs[k].len);
            req_phase(N'(1) << vecs[k].m, g, w);
            chk("vec_grant", 64'(g), 64'(vecs[k].m));
            chk("vec_arready_now", 64'(w), 0);
            serve(g, vecs[k].nbeats, vecs[k].stall, vecs[k].rnd, got, errs);
            chk("vec_beats", 64'(got), 64'(vecs[k].nbeats));
            chk("vec_len_err", 64'(errs), 64'(vecs[k].exp_err));
        end

        // Two masters competing after reset alternate starting with master 0.
        do_reset();
        for (int r = 0; r < 4; r++) begin
            set_req(0, 32'h100 + 32'(r), 4'h0, 8'd0);
            set_req(1, 32'h200 + 32'(r), 4'h1, 8'd0);
            req_phase(3'b011, g, w);
            chk("alt_grant", 64'(g), 64'(r % 2));
            serve(g, 1, 0, 1'b0, got, errs);
            chk("alt_beats", 64'(got), 1);
        end

        // Reset in the middle of a data phase.
        set_req(1, 32'h9000, 4'h9, 8'd3);
        req_phase(3'b010, g, w);
        chk("mid_grant", 64'(g), 1);
        s_arready = 1'b1;
        step();
        s_arready = 1'b0;
        s_rvalid = 1'b1;
        s_rlast = 1'b0;
        s_rdata = 64'h1234;
        m_rready = '1;
        #1;
        chk("mid_rvalid", 64'(m_rvalid[1]), 1);
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst_rvalid", 64'(m_rvalid), 0);
        chk("mid_rst_rready", 64'(s_rready), 0);
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_grant", 64'(grant), 0);
        chk("mid_rst_ar", 64'({s_arvalid, s_araddr}), 0);
        step();
        rst = 1'b0;
        s_rvalid = 1'b0;
        m_rready = '0;
        set_req(0, 32'hA000, 4'hA, 8'd0);
        set_req(1, 32'hB000, 4'hB, 8'd0);
        req_phase(3'b011, g, w);
        chk("post_rst_grant", 64'(g), 0);
        serve(g, 1, 0, 1'b0, got, errs);
        chk("post_rst_beats", 64'(got), 1);

        // Randomized bursts against the rotating-priority model.
        do_reset();
        last = N - 1;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) begin
                req_addr[i]  = $urandom();
                req_id[i]    = 4'($urandom());
                req_len[i]   = 8'($urandom_range(0, 4));
                req_size[i]  = 3'($urandom());
                req_burst[i] = 2'($urandom_range(0, 2));
            end
            mask = N'($urandom_range(1, (1 << N) - 1));
            exp_g = model_pick(mask, last);
            req_phase(mask, g, w);
            chk("rand_grant", 64'(g), 64'(exp_g));
            nb = int'(req_len[g]) + 1;
            case ($urandom_range(0, 3))
                0: nb = nb + 1;
                1: if (nb > 1) nb = nb - 1;
                default: ;
            endcase
            exp_err = (nb != int'(req_len[g]) + 1) ? 1 : 0;
            serve(g, nb, $urandom_range(0, 2), 1'b1, got, errs);
            chk("rand_beats", 64'(got), 64'(nb));
            chk("rand_len_err", 64'(errs), 64'(exp_err));
            last = exp_g;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
